// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// The borrow is carried between digits in a register; a start/done handshake frames each operation.
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, diff_reg;
   logic             a_msb_reg, b_msb_reg;
   logic             borrow_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg, done_reg, bout_reg, ovf_reg;

   logic             accept, last_step;
   logic [DIGIT-1:0] dig;
   logic             br_out;

   // Borrow ripples through the low DIGIT bits of the operand shift registers.
   always_comb begin
      logic br;
      br  = borrow_reg;
      dig = '0;
      for (int i = 0; i < DIGIT; i++) begin
         dig[i] = a_sh_reg[i] ^ b_sh_reg[i] ^ br;
         br     = (~a_sh_reg[i] & b_sh_reg[i]) | (~a_sh_reg[i] & br) | (b_sh_reg[i] & br);
      end
      br_out = br;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt_reg == CW'(STEPS - 1)) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
         diff_reg   <= '0;
         bout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         busy_reg <= (state_next == RUN);
         done_reg <= (state_next == DONE);
         if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
            borrow_reg <= bin;
            cnt_reg    <= '0;
         end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> DIGIT;
            b_sh_reg   <= b_sh_reg >> DIGIT;
            borrow_reg <= br_out;
            cnt_reg    <= cnt_reg + CW'(1);
            // New digit enters at the top; after STEPS shifts digit 0 sits at the LSB.
            diff_reg   <= (WIDTH'(dig) << (WIDTH - DIGIT)) | (diff_reg >> DIGIT);
            if (last_step) begin
               bout_reg <= br_out;
               ovf_reg  <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ dig[DIGIT-1]);
            end
         end
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign diff = diff_reg;
   assign bout = bout_reg;
   assign ovf  = ovf_reg;

endmodule
